// File: rtl/data_memory_if.sv
// Request/response bundle for data_memory: the requester drives the access,
// the memory returns registered read data and the one-cycle status pulses.
interface data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();

  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  read_valid;
  logic                  access_err;

  modport master (
    output mem_read, mem_write, size, sign_ext, address, data_in,
    input  data_out, read_valid, access_err
  );

  modport slave (
    input  mem_read, mem_write, size, sign_ext, address, data_in,
    output data_out, read_valid, access_err
  );

endinterface

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory with sub-word access, 1-cycle reads
// and alignment checking.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int WORD_BITS = ADDR_WIDTH - LANE_BITS;
  localparam int DEPTH     = 1 << WORD_BITS;

  logic [BYTES-1:0][7:0] mem [DEPTH];

  logic [WORD_BITS-1:0]  word_idx;
  logic [LANE_BITS-1:0]  lane_off;
  logic [3:0]            acc_bytes;
  logic                  misaligned;
  logic                  size_illegal;
  logic                  legal;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  read_valid_next;
  logic                  access_err_next;
  logic [4:0]            lane_hi;
  logic [BYTES-1:0]      lane_we;
  logic [DATA_WIDTH-1:0] wdata_shift;

  logic [DATA_WIDTH-1:0] rd_word_reg;
  logic [LANE_BITS-1:0]  rd_off_reg;
  logic [1:0]            rd_size_reg;
  logic                  rd_sext_reg;
  logic                  read_valid_reg;
  logic                  access_err_reg;

  logic [DATA_WIDTH-1:0] rd_shifted;
  logic [DATA_WIDTH-1:0] rd_mask;
  logic                  rd_sign;
  logic [DATA_WIDTH-1:0] data_out_next;

  assign word_idx = bus.address[ADDR_WIDTH-1:LANE_BITS];
  assign lane_off = bus.address[LANE_BITS-1:0];

  always_comb begin
    acc_bytes  = 4'd1;
    misaligned = 1'b0;
    case (bus.size)
      2'b00: begin acc_bytes = 4'd1; misaligned = 1'b0;              end
      2'b01: begin acc_bytes = 4'd2; misaligned = bus.address[0];    end
      2'b10: begin acc_bytes = 4'd4; misaligned = |bus.address[1:0]; end
      default: begin acc_bytes = 4'd8; misaligned = |bus.address[2:0]; end
    endcase
  end

  assign size_illegal = (bus.size == 2'b11) && (DATA_WIDTH == 32);
  assign legal        = !misaligned && !size_illegal;

  // Write wins over a simultaneous read; a rejected access touches nothing.
  assign wr_fire         = bus.mem_write && legal;
  assign rd_fire         = bus.mem_read && !bus.mem_write && legal;
  assign read_valid_next = rd_fire;
  assign access_err_next = (bus.mem_read || bus.mem_write) && !legal;

  assign lane_hi     = 5'(lane_off) + 5'(acc_bytes);
  assign wdata_shift = bus.data_in << {lane_off, 3'b000};

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : gen_lane_we
      assign lane_we[gi] = wr_fire && (5'(gi) >= 5'(lane_off)) && (5'(gi) < lane_hi);
    end
  endgenerate

  // Array is never cleared; reset only blocks writes while it is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < BYTES; i++) begin
        if (lane_we[i]) begin
          mem[word_idx][i] <= wdata_shift[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_word_reg    <= '0;
      rd_off_reg     <= '0;
      rd_size_reg    <= 2'b00;
      rd_sext_reg    <= 1'b0;
      read_valid_reg <= 1'b0;
      access_err_reg <= 1'b0;
    end else begin
      read_valid_reg <= read_valid_next;
      access_err_reg <= access_err_next;
      if (rd_fire) begin
        rd_word_reg <= mem[word_idx];
        rd_off_reg  <= lane_off;
        rd_size_reg <= bus.size;
        rd_sext_reg <= bus.sign_ext;
      end
    end
  end

  // Lane extraction works on the captured word, so data_out holds between reads
  // and is all-zero while the capture registers sit in reset.
  always_comb begin
    rd_shifted = rd_word_reg >> {rd_off_reg, 3'b000};
    rd_mask    = '1;
    rd_sign    = 1'b0;
    case (rd_size_reg)
      2'b00: begin rd_mask = DATA_WIDTH'(8'hFF);         rd_sign = rd_shifted[7];  end
      2'b01: begin rd_mask = DATA_WIDTH'(16'hFFFF);      rd_sign = rd_shifted[15]; end
      2'b10: begin rd_mask = DATA_WIDTH'(32'hFFFF_FFFF); rd_sign = rd_shifted[31]; end
      default: begin rd_mask = '1;                       rd_sign = 1'b0;           end
    endcase
    data_out_next = (rd_shifted & rd_mask) | ((rd_sext_reg && rd_sign) ? ~rd_mask : '0);
  end

  assign bus.data_out   = data_out_next;
  assign bus.read_valid = read_valid_reg;
  assign bus.access_err = access_err_reg;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: each driven access pushes its expected
// response, which a monitor pops and compares one cycle later.
module tb_data_memory;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    bit          valid;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  model_mem [256];
  logic [31:0] model_dout = 32'h0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] sz, input bit sx, input logic [7:0] a);
    int n = 1 << sz;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = model_mem[int'(a) + i];
    if (sx && n < 4 && v[n*8-1]) begin
      for (int b = n*8; b < 32; b++) v[b] = 1'b1;
    end
    return v;
  endfunction

  task automatic drive(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                       input logic [7:0] a, input logic [31:0] d);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.size      = sz;
    bus.sign_ext  = sx;
    bus.address   = a;
    bus.data_in   = d;
  endtask

  task automatic op(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                    input bit sx, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    int   n;
    bit   legal;
    @(negedge clk);
    drive(rd, wr, sz, sx, a, d);
    n     = 1 << sz;
    legal = (sz != 2'b11) && ((int'(a) % n) == 0);
    e.tag   = tag;
    e.valid = 1'b0;
    e.err   = 1'b0;
    if ((rd || wr) && !legal) begin
      e.err = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < n; i++) model_mem[int'(a) + i] = d[i*8 +: 8];
    end else if (rd) begin
      model_dout = model_read(sz, sx, a);
      e.valid    = 1'b1;
    end
    e.data = model_dout;
    sb.push_back(e);
    $display("op %-12s rd=%0b wr=%0b size=%0d sx=%0b addr=%0d din=0x%08h -> valid=%0b err=%0b dout=0x%08h",
             tag, rd, wr, sz, sx, a, d, e.valid, e.err, e.data);
  endtask

  // Monitor: one expected response per driven cycle, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check_eq({cur.tag, " read_valid"}, 64'(bus.read_valid), 64'(cur.valid));
      check_eq({cur.tag, " access_err"}, 64'(bus.access_err), 64'(cur.err));
      check_eq({cur.tag, " data_out"},   64'(bus.data_out),   64'(cur.data));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset data_out",   64'(bus.data_out),   64'h0);
    check_eq("reset read_valid", 64'(bus.read_valid), 64'h0);
    check_eq("reset access_err", 64'(bus.access_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    op("wr20",     1'b0, 1'b1, 2'b10, 1'b0, 8'd20, 32'h0000_0211);
    op("rd20",     1'b1, 1'b0, 2'b10, 1'b0, 8'd20, 32'h0);
    op("wr24",     1'b0, 1'b1, 2'b10, 1'b0, 8'd24, 32'hAABB_CCDD);
    op("wrb25",    1'b0, 1'b1, 2'b00, 1'b0, 8'd25, 32'h0000_0011);
    op("rd24",     1'b1, 1'b0, 2'b10, 1'b0, 8'd24, 32'h0);
    op("wr28",     1'b0, 1'b1, 2'b10, 1'b0, 8'd28, 32'h0000_80F0);
    op("rdh28s",   1'b1, 1'b0, 2'b01, 1'b1, 8'd28, 32'h0);
    op("rdh28z",   1'b1, 1'b0, 2'b01, 1'b0, 8'd28, 32'h0);
    op("rdb29s",   1'b1, 1'b0, 2'b00, 1'b1, 8'd29, 32'h0);
    op("wr30mis",  1'b0, 1'b1, 2'b10, 1'b0, 8'd30, 32'hDEAD_BEEF);
    op("rd28",     1'b1, 1'b0, 2'b10, 1'b0, 8'd28, 32'h0);
    op("rdh29mis", 1'b1, 1'b0, 2'b01, 1'b0, 8'd29, 32'h0);
    op("rdd64ill", 1'b1, 1'b0, 2'b11, 1'b0, 8'd32, 32'h0);
    op("idle",     1'b0, 1'b0, 2'b00, 1'b0, 8'd0,  32'h0);
    op("rdwr32",   1'b1, 1'b1, 2'b10, 1'b0, 8'd32, 32'h1234_5678);
    op("rd32",     1'b1, 1'b0, 2'b10, 1'b0, 8'd32, 32'h0);
    op("rdb35z",   1'b1, 1'b0, 2'b00, 1'b0, 8'd35, 32'h0);

    for (int w = 64; w < 128; w += 4) begin
      op("prefill", 1'b0, 1'b1, 2'b10, 1'b0, 8'(w), $urandom);
    end
    for (int k = 0; k < 48; k++) begin
      op("rand", 1'($urandom), 1'($urandom_range(0, 3) == 0), 2'($urandom),
         1'($urandom), 8'(64 + $urandom_range(0, 63)), $urandom);
    end

    // Reset asserted while a read result is on the outputs and another read is pending.
    op("rd24pre",  1'b1, 1'b0, 2'b10, 1'b0, 8'd24, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst data_out",   64'(bus.data_out),   64'h0);
    check_eq("midrst read_valid", 64'(bus.read_valid), 64'h0);
    @(posedge clk);
    #1;
    check_eq("inrst read_valid",  64'(bus.read_valid), 64'h0);
    check_eq("inrst data_out",    64'(bus.data_out),   64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 32'h0);
    rst_n      = 1'b1;
    model_dout = 32'h0;

    op("postrst",  1'b0, 1'b0, 2'b00, 1'b0, 8'd0,  32'h0);
    op("rd20post", 1'b1, 1'b0, 2'b10, 1'b0, 8'd20, 32'h0);
    op("rd24post", 1'b1, 1'b0, 2'b10, 1'b0, 8'd24, 32'h0);
    op("rd32post", 1'b1, 1'b0, 2'b10, 1'b0, 8'd32, 32'h0);
    op("idle_end", 1'b0, 1'b0, 2'b00, 1'b0, 8'd0,  32'h0);

    repeat (2) @(posedge clk);
    #2;
    check_eq("scoreboard drained", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, byte-address width; depth SHALL be 2^ADDR_WIDTH/(DATA_WIDTH/8) words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port mem_read, input, 1 bit: read request, sampled at the rising edge.
REQ-006 The block SHALL have port mem_write, input, 1 bit: write request, sampled at the rising edge.
REQ-007 The block SHALL have port size, input, 2 bits: access size (00 byte, 01 half, 10 word32, 11 dword64).
REQ-008 The block SHALL have port sign_ext, input, 1 bit: sign-extend sub-word reads when 1, zero-extend when 0.
REQ-009 The block SHALL have port address, input, ADDR_WIDTH bits: byte address.
REQ-010 The block SHALL have port data_in, input, DATA_WIDTH bits: write data, right-aligned (LSBs used for sub-word writes).
REQ-011 The block SHALL have port data_out, output, DATA_WIDTH bits: registered read data, right-aligned.
REQ-012 The block SHALL have port read_valid, output, 1 bit: one-cycle pulse marking data_out as updated.
REQ-013 The block SHALL have port access_err, output, 1 bit: one-cycle pulse flagging a rejected access.

Function
REQ-014 Byte lane mapping SHALL be little-endian: byte at address a occupies word a/(DATA_WIDTH/8), lane a mod (DATA_WIDTH/8).
REQ-015 A write SHALL update only the lanes covered by size at address on the rising edge; other lanes keep their values.
REQ-016 A read SHALL have 1-cycle latency: data_out and read_valid=1 appear after the rising edge that sampled mem_read=1.
REQ-017 Sub-word read data SHALL be extracted from the addressed lanes and sign- or zero-extended to DATA_WIDTH per sign_ext.
REQ-018 data_out SHALL hold its last value when no valid read occurs; read_valid SHALL be 0 in that cycle.
REQ-019 An access is misaligned when address mod (access bytes) != 0; size=11 with DATA_WIDTH=32 SHALL also be illegal.
REQ-020 A misaligned or illegal access SHALL modify no memory, leave data_out unchanged, and pulse access_err=1 for one cycle (read_valid=0).
REQ-021 With mem_read and mem_write both 1, the write SHALL be performed and the read SHALL be ignored (read_valid=0, access_err=0).
REQ-022 A read in the cycle immediately after a write to the same word SHALL return the newly written data.
REQ-023 Addresses SHALL cover the full ADDR_WIDTH space with no wrap or out-of-range case.

Reset
REQ-024 While rst_n=0, data_out SHALL be 0, read_valid 0, access_err 0, asynchronously on assertion.
REQ-025 Reset SHALL NOT clear memory contents; a write or read in progress at reset assertion SHALL be discarded.
REQ-026 The first access SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-027 With macro DATA_MEMORY_INIT_EN defined, the array SHALL be preloaded at time zero from hex file "data_memory.hex" (one DATA_WIDTH word per line).
REQ-028 Without DATA_MEMORY_INIT_EN, array contents SHALL be undefined until written, and no file access SHALL occur.

Verification
REQ-029 Word write 0x0000_0211 to address 20, then word read at 20 -> data_out=0x0000_0211, read_valid=1 one cycle later.
REQ-030 Word 0xAABBCCDD at address 24; byte write 0x11 to address 25; word read at 24 -> 0xAABB11DD.
REQ-031 Word 0x000080F0 at address 28; half read at 28 with sign_ext=1 -> 0xFFFF80F0; with sign_ext=0 -> 0x000080F0; byte read at 29 with sign_ext=1 -> 0xFFFFFF80.
REQ-032 Word write to address 30 (misaligned) -> access_err pulse, word at 28 unchanged on re-read.
REQ-033 mem_read=mem_write=1 at address 32 with data_in=0x12345678 -> read_valid=0; subsequent read -> 0x12345678.
REQ-034 Assert rst_n=0 mid-read -> data_out=0 and read_valid=0 immediately; after release, earlier written words are still readable.
